aes_inv_cipher: RTL and testbench

//  Iterative AES inverse cipher (FIPS-197 InvCipher): one decryption round per clock, start/done handshake.

---
 rtl/aes_pkg.sv | 58 +++++
 rtl/aes_inv_round.sv | 55 +++++
 rtl/aes_inv_cipher.sv | 133 +++++++++++++
 tb/tb_aes_inv_cipher.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES inverse cipher: inverse S-box, GF(2^8) helpers,
// FSM state encoding and key-length legality check.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROUNDS = 2'd1,
    ST_FINAL  = 2'd2
  } aes_fsm_e;

  localparam int NR_MAX = 14;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic bit nk_legal(input int nk);
    return (nk == 32'sd4) || (nk == 32'sd6) || (nk == 32'sd8);
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  // Multiply by x modulo the AES polynomial 0x11B
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      else      acc = acc;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES decryption round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the last round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [127:0] shifted_s;
  logic [127:0] keyed_s;
  logic [127:0] mixed_s;
  logic [7:0]   a0_s, a1_s, a2_s, a3_s;

  // Byte k = 4*col + row lives at bits [127-8k -: 8]; row r rotates right by r columns
  always_comb begin
    shifted_s = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted_s[127 - 8*(4*c + r) -: 8] = state_in[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
      end
    end
  end

  always_comb begin
    keyed_s = 128'h0;
    for (int k = 0; k < 16; k++) begin
      keyed_s[127 - 8*k -: 8] = inv_sbox(shifted_s[127 - 8*k -: 8]) ^ rk[127 - 8*k -: 8];
    end
  end

  // InvMixColumns with coefficient row {0e, 0b, 0d, 09}
  always_comb begin
    mixed_s = 128'h0;
    a0_s    = 8'h00;
    a1_s    = 8'h00;
    a2_s    = 8'h00;
    a3_s    = 8'h00;
    for (int c = 0; c < 4; c++) begin
      a0_s = keyed_s[127 - 32*c -: 8];
      a1_s = keyed_s[119 - 32*c -: 8];
      a2_s = keyed_s[111 - 32*c -: 8];
      a3_s = keyed_s[103 - 32*c -: 8];
      mixed_s[127 - 32*c -: 8] = gf_mul(a0_s, 8'h0e) ^ gf_mul(a1_s, 8'h0b) ^ gf_mul(a2_s, 8'h0d) ^ gf_mul(a3_s, 8'h09);
      mixed_s[119 - 32*c -: 8] = gf_mul(a0_s, 8'h09) ^ gf_mul(a1_s, 8'h0e) ^ gf_mul(a2_s, 8'h0b) ^ gf_mul(a3_s, 8'h0d);
      mixed_s[111 - 32*c -: 8] = gf_mul(a0_s, 8'h0d) ^ gf_mul(a1_s, 8'h09) ^ gf_mul(a2_s, 8'h0e) ^ gf_mul(a3_s, 8'h0b);
      mixed_s[103 - 32*c -: 8] = gf_mul(a0_s, 8'h0b) ^ gf_mul(a1_s, 8'h0d) ^ gf_mul(a2_s, 8'h09) ^ gf_mul(a3_s, 8'h0e);
    end
  end

  assign state_out = last ? keyed_s : mixed_s;

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES inverse cipher, one round per clock with start/done handshake.
// Define AES_INV_KEY_LATCH_EN to snapshot the key schedule on the accepting edge.
module aes_inv_cipher
  import aes_pkg::*;
#(
  parameter int  Nk = 4,
  localparam int Nr = Nk + 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [127:0]             cipherText,
  input  logic [0:128*(Nr+1)-1]    keys,
  output logic [127:0]             plainText,
  output logic                     busy,
  output logic                     done
);

  localparam logic [3:0] FIRST_ROUND = 4'(Nr - 1);

  if (!nk_legal(Nk) || (Nr > NR_MAX)) begin : g_bad_nk
    $error("aes_inv_cipher: Nk must be 4, 6 or 8");
  end

  aes_fsm_e                fsm_r, fsm_next_s;
  logic [3:0]              round_r, round_next_s;
  logic [127:0]            state_r, state_next_s;
  logic [127:0]            pt_next_s;
  logic                    busy_next_s, done_next_s;
  logic [0:128*(Nr+1)-1]   key_src_s;
  logic [127:0]            rk_arr_s [0:Nr];
  logic [3:0]              rk_idx_s;
  logic [127:0]            rk_sel_s;
  logic [127:0]            first_key_s;
  logic [127:0]            round_out_s;
  logic                    last_s;

`ifdef AES_INV_KEY_LATCH_EN
  logic [0:128*(Nr+1)-1]   key_r;

  // Snapshot of the whole schedule taken on the accepting edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_r <= '0;
    end else if ((fsm_r == ST_IDLE) && start) begin
      key_r <= keys;
    end else begin
      key_r <= key_r;
    end
  end

  assign key_src_s = key_r;
`else
  assign key_src_s = keys;
`endif

  for (genvar i = 0; i <= Nr; i++) begin : g_rk
    assign rk_arr_s[i] = key_src_s[128*i +: 128];
  end

  // The initial whitening key is taken live: the snapshot only exists after this edge
  assign first_key_s = keys[128*Nr +: 128];
  assign last_s      = (fsm_r == ST_FINAL);
  assign rk_idx_s    = last_s ? 4'd0 : round_r;
  assign rk_sel_s    = rk_arr_s[rk_idx_s];

  aes_inv_round u_round (
    .state_in  (state_r),
    .rk        (rk_sel_s),
    .last      (last_s),
    .state_out (round_out_s)
  );

  // Next-state and output-register decode
  always_comb begin
    fsm_next_s   = fsm_r;
    round_next_s = round_r;
    state_next_s = state_r;
    pt_next_s    = plainText;
    busy_next_s  = busy;
    done_next_s  = 1'b0;
    case (fsm_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = cipherText ^ first_key_s;
          round_next_s = FIRST_ROUND;
          busy_next_s  = 1'b1;
          fsm_next_s   = ST_ROUNDS;
        end else begin
          fsm_next_s   = ST_IDLE;
        end
      end
      ST_ROUNDS: begin
        state_next_s = round_out_s;
        if (round_r == 4'd1) begin
          fsm_next_s   = ST_FINAL;
        end else begin
          round_next_s = round_r - 4'd1;
        end
      end
      ST_FINAL: begin
        pt_next_s   = round_out_s;
        done_next_s = 1'b1;
        busy_next_s = 1'b0;
        fsm_next_s  = ST_IDLE;
      end
      default: begin
        busy_next_s = 1'b0;
        fsm_next_s  = ST_IDLE;
      end
    endcase
  end

  // Control, datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_r     <= ST_IDLE;
      round_r   <= 4'd0;
      state_r   <= 128'h0;
      plainText <= 128'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      fsm_r     <= fsm_next_s;
      round_r   <= round_next_s;
      state_r   <= state_next_s;
      plainText <= pt_next_s;
      busy      <= busy_next_s;
      done      <= done_next_s;
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Self-checking bench for aes_inv_cipher: FIPS-197 vectors for all key sizes, handshake
// corner cases and a round trip against a bench-side forward cipher and key expansion.
module tb_aes_inv_cipher;

  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_F   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic          clk = 1'b0;
  logic          reset;
  logic          tb_start;
  logic [127:0]  ct_in;
  int            cur_nk;
  logic [0:1407] keys4;
  logic [0:1663] keys6;
  logic [0:1919] keys8;
  logic          start4, start6, start8;
  logic [127:0]  pt4, pt6, pt8, pt_m;
  logic          busy4, busy6, busy8, busy_m;
  logic          done4, done6, done8, done_m;
  logic [127:0]  rk_m [0:14];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  assign start4 = tb_start && (cur_nk == 4);
  assign start6 = tb_start && (cur_nk == 6);
  assign start8 = tb_start && (cur_nk == 8);

  always_comb begin
    case (cur_nk)
      6:       begin pt_m = pt6; busy_m = busy6; done_m = done6; end
      8:       begin pt_m = pt8; busy_m = busy8; done_m = done8; end
      default: begin pt_m = pt4; busy_m = busy4; done_m = done4; end
    endcase
  end

  aes_inv_cipher #(.Nk(4)) u_dut4 (.clk(clk), .reset(reset), .start(start4), .cipherText(ct_in),
                                   .keys(keys4), .plainText(pt4), .busy(busy4), .done(done4));
  aes_inv_cipher #(.Nk(6)) u_dut6 (.clk(clk), .reset(reset), .start(start6), .cipherText(ct_in),
                                   .keys(keys6), .plainText(pt6), .busy(busy6), .done(done6));
  aes_inv_cipher #(.Nk(8)) u_dut8 (.clk(clk), .reset(reset), .start(start8), .cipherText(ct_in),
                                   .keys(keys8), .plainText(pt8), .busy(busy8), .done(done8));

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nw;
    nw = 4 * (nk + 7);
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nk + 6; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Shift round keys in so rk[0] ends up leftmost (keys[0:127])
  task automatic pack_keys(input int nk);
    for (int r = 0; r <= nk + 6; r++) begin
      case (nk)
        6:       keys6 = {keys6[128:1663], rk_m[r]};
        8:       keys8 = {keys8[128:1919], rk_m[r]};
        default: keys4 = {keys4[128:1407], rk_m[r]};
      endcase
    end
  endtask

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input int nr);
    logic [127:0] s, t;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ rk_m[0];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int k = 0; k < 16; k++) s[127 - 8*k -: 8] = SBOX[s[127 - 8*k -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
      if (rd != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[127 - 32*c -: 8]; a1 = t[119 - 32*c -: 8];
          a2 = t[111 - 32*c -: 8]; a3 = t[103 - 32*c -: 8];
          t[127 - 32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[119 - 32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[111 - 32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[103 - 32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      s = t ^ rk_m[rd];
    end
    return s;
  endfunction

  task automatic run_block(input int nk, input logic [127:0] ct, input logic [127:0] exp_pt,
                           input string tag, input bit full);
    int lat;
    cur_nk = nk;
    @(negedge clk); ct_in = ct; tb_start = 1'b1;
    @(posedge clk); #1;
    if (full) check_val({tag, "_busy_hi"}, 128'(busy_m), 128'd1);
    @(negedge clk); tb_start = 1'b0; ct_in = ~ct;
    lat = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (done_m) begin lat = e; break; end
    end
    if (full) check_val({tag, "_latency"}, 128'(lat), 128'(nk + 6));
    check_val({tag, "_pt"}, pt_m, exp_pt);
    if (full) begin
      check_val({tag, "_busy_lo"}, 128'(busy_m), 128'd0);
      @(posedge clk); #1;
      check_val({tag, "_done_pulse"}, 128'(done_m), 128'd0);
    end
  endtask

  initial begin
    logic [127:0] pt_x, ct_x, pt_at_done, key_lo, key_hi;
    logic [127:0] pts [3];
    logic [127:0] cts [3];
    int done_cnt, first_e, idx, last_e, e, nk;

    reset = 1'b1; tb_start = 1'b0; ct_in = 128'h0; cur_nk = 4;
    keys4 = '0; keys6 = '0; keys8 = '0;
    #1;
    check_val("rst_pt4", pt4, 128'h0);
    check_val("rst_busy4", 128'(busy4), 128'd0);
    check_val("rst_done4", 128'(done4), 128'd0);
    check_val("rst_pt8", pt8, 128'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    expand_key(KEY128, 4); pack_keys(4);
    run_block(4, CT128, PT_F, "fips128", 1'b1);
    expand_key(KEY192, 6); pack_keys(6);
    run_block(6, CT192, PT_F, "fips192", 1'b1);
    expand_key(KEY256, 8); pack_keys(8);
    run_block(8, CT256, PT_F, "fips256", 1'b1);

    // start pulses while busy must be ignored
    expand_key(KEY128, 4);
    pt_x = {$urandom(), $urandom(), $urandom(), $urandom()};
    ct_x = aes_encrypt(pt_x, 10);
    cur_nk = 4; done_cnt = 0; first_e = -1; pt_at_done = 128'h0;
    @(negedge clk); ct_in = ct_x; tb_start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk); tb_start = (k == 3) || (k == 6); ct_in = tb_start ? ~ct_x : ct_x;
      @(posedge clk); #1;
      if (done4) begin
        done_cnt++;
        if (first_e < 0) begin first_e = k; pt_at_done = pt4; end
      end
    end
    check_val("ign_done_count", 128'(done_cnt), 128'd1);
    check_val("ign_latency", 128'(first_e), 128'd10);
    check_val("ign_pt", pt_at_done, pt_x);

    // Reset five edges into a block aborts it cleanly
    @(negedge clk); ct_in = CT128; tb_start = 1'b1;
    @(posedge clk);
    @(negedge clk); tb_start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_val("abort_pt", pt4, 128'h0);
    check_val("abort_busy", 128'(busy4), 128'd0);
    check_val("abort_done", 128'(done4), 128'd0);
    @(negedge clk); reset = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (done4) done_cnt++;
    end
    check_val("abort_no_done", 128'(done_cnt), 128'd0);
    run_block(4, CT128, PT_F, "after_rst", 1'b1);

    // start held high: back-to-back blocks every 11 edges
    pts[0] = PT_F; cts[0] = CT128;
    for (int k = 1; k < 3; k++) begin
      pts[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
      cts[k] = aes_encrypt(pts[k], 10);
    end
    cur_nk = 4; idx = 0; last_e = 0; e = 0;
    @(negedge clk); ct_in = cts[0]; tb_start = 1'b1;
    while (idx < 3 && e < 80) begin
      @(posedge clk); #1; e++;
      if (done4) begin
        check_val("b2b_pt", pt4, pts[idx]);
        check_val("b2b_spacing", 128'(e - last_e), 128'd11);
        last_e = e; idx++;
        if (idx < 3) ct_in = cts[idx];
        else tb_start = 1'b0;
`ifdef AES_INV_KEY_LATCH_EN
        pack_keys(4);
      end else begin
        for (int j = 0; j < 44; j++) keys4 = {keys4[32:1407], $urandom()};
`endif
      end
    end
    tb_start = 1'b0;
    pack_keys(4);
    check_val("b2b_count", 128'(idx), 128'd3);

    // Round trip against the bench encryptor, cycling key sizes
    for (int i = 0; i < 1000; i++) begin
      nk = (i % 3 == 0) ? 4 : ((i % 3 == 1) ? 6 : 8);
      key_hi = {$urandom(), $urandom(), $urandom(), $urandom()};
      key_lo = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand_key({key_hi, key_lo}, nk); pack_keys(nk);
      pt_x = {$urandom(), $urandom(), $urandom(), $urandom()};
      ct_x = aes_encrypt(pt_x, nk + 6);
      run_block(nk, ct_x, pt_x, "roundtrip", 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
